bcd_serial_adder: RTL and testbench



---
 rtl/bcd_serial_adder.sv | 146 ++++++++++++++
 tb/tb_bcd_serial_adder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial multi-digit BCD adder, one decimal digit per clock, LSD first.
// Latency: DIGITS+1 edges from the start sample to the done pulse; one addition per DIGITS+1 cycles.
// Backpressure: none; start is only sampled in IDLE, so a start during an addition is ignored.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   start           begin an addition (sampled in IDLE only)
//   a, b            packed BCD operands, digit i at [4i+3:4i]
//   cin             decimal carry into digit 0
//   busy            high while digits are being processed
//   done            one-cycle pulse when sum/cout/err update
//   sum, cout, err  registered result, held until the next completion
//
// Optional feature: define BCD_INVALID_CHECK_EN to flag operand digits > 9 on err.
// Without it err is tied low and the port list is unchanged.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic {IDLE, ADD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  acc;
  logic          carry;

  // Single digit adder working on the low digit of the operand shift registers.
  logic [5:0]    t;
  logic [3:0]    dig;
  logic          dig_carry;
  logic [W-1:0]  acc_next;

  always_comb begin
    t = {2'b00, a_sh[3:0]} + {2'b00, b_sh[3:0]} + {5'b00000, carry};
    if (t > 6'd9) begin
      // (t + 6) mod 16; also covers non-BCD inputs deterministically.
      dig       = t[3:0] + 4'd6;
      dig_carry = 1'b1;
    end else begin
      dig       = t[3:0];
      dig_carry = 1'b0;
    end
  end

  // New digit enters at the top so that after DIGITS shifts digit 0 sits at the bottom.
  generate
    if (DIGITS == 1) begin : g_acc_one
      assign acc_next = dig;
    end else begin : g_acc_multi
      assign acc_next = {dig, acc[W-1:4]};
    end
  endgenerate

`ifdef BCD_INVALID_CHECK_EN
  logic inv_in;
  logic inv_q;

  always_comb begin
    inv_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
        inv_in = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
      inv_q <= 1'b0;
      err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= ADD;
`ifdef BCD_INVALID_CHECK_EN
            inv_q <= inv_in;
`endif
          end
        end
        ADD: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          acc   <= acc_next;
          carry <= dig_carry;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= dig_carry;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
`ifdef BCD_INVALID_CHECK_EN
            err   <= inv_q;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BCD_INVALID_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Reference: decimal digit-by-digit addition with +6 correction, returns {cout, sum}.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    int           c;
    int           t;
    logic [W-1:0] s;
    c = int'(ci);
    s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + c;
      if (t > 9) begin
        s[4*i +: 4] = 4'((t + 6) % 16);
        c = 1;
      end else begin
        s[4*i +: 4] = 4'(t);
        c = 0;
      end
    end
    return {c[0], s};
  endfunction

  function automatic logic ref_err(input logic [W-1:0] x, input logic [W-1:0] y);
    logic e;
    e = 1'b0;
`ifdef BCD_INVALID_CHECK_EN
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(x[4*i +: 4]) > 9 || int'(y[4*i +: 4]) > 9) e = 1'b1;
    end
`else
    e = (x == '0) && (y == '0) && 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: launches one addition and checks timing and result.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input string tag);
    logic [W:0] exp;
    int         lat;
    int         bz;
    exp   = ref_add(xa, xb, xc);
    lat   = 0;
    bz    = 0;
    a     = xa;
    b     = xb;
    cin   = xc;
    start = 1'b1;
    while (lat < 20) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) break;
      if (busy) bz++;
    end
    check({tag, "/latency"}, lat, DIGITS + 1);
    check({tag, "/busy_cycles"}, bz, DIGITS);
    check({tag, "/busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, "/sum"}, {16'b0, sum}, {16'b0, exp[W-1:0]});
    check({tag, "/cout"}, {31'b0, cout}, {31'b0, exp[W]});
    check({tag, "/err"}, {31'b0, err}, {31'b0, ref_err(xa, xb)});
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    logic [W:0]   exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           ndone;
    logic [W-1:0] cap_sum;
    logic         cap_cout;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst/busy", {31'b0, busy}, 32'd0);
    check("rst/done", {31'b0, done}, 32'd0);
    check("rst/sum",  {16'b0, sum},  32'd0);
    check("rst/cout", {31'b0, cout}, 32'd0);
    check("rst/err",  {31'b0, err},  32'd0);

    // rst and start together: reset wins.
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h1111;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start/busy", {31'b0, busy}, 32'd0);

    // Basic addition.
    run_op(16'h1234, 16'h5678, 1'b0, "basic");
    check("basic/sum_const", {16'b0, sum}, 32'h6912);

    // Output hold after completion.
    repeat (3) @(negedge clk);
    check("hold/done", {31'b0, done}, 32'd0);
    check("hold/sum",  {16'b0, sum},  32'h6912);

    // Full carry ripple.
    run_op(16'h4999, 16'h5001, 1'b0, "ripple");
    check("ripple/sum_const",  {16'b0, sum},  32'h0000);
    check("ripple/cout_const", {31'b0, cout}, 32'd1);

    // Carry-in ripple then back-to-back start in the done cycle.
    run_op(16'h9999, 16'h0000, 1'b1, "cin");
    check("cin/cout_const", {31'b0, cout}, 32'd1);
    run_op(16'h0001, 16'h0001, 1'b0, "b2b");
    check("b2b/sum_const", {16'b0, sum}, 32'h0002);

    // Start re-asserted with changed operands mid-operation.
    exp   = ref_add(16'h2468, 16'h1357, 1'b0);
    a     = 16'h2468;
    b     = 16'h1357;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    a     = 16'h9999;
    b     = 16'h9999;
    cin   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    ndone    = 0;
    cap_sum  = '0;
    cap_cout = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        cap_sum  = sum;
        cap_cout = cout;
      end
    end
    check("restart/done_count", ndone, 32'd1);
    check("restart/sum",  {16'b0, cap_sum},  {16'b0, exp[W-1:0]});
    check("restart/cout", {31'b0, cap_cout}, {31'b0, exp[W]});

    // Reset in the middle of an addition aborts it.
    a     = 16'h1234;
    b     = 16'h1111;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    check("abort/busy", {31'b0, busy}, 32'd0);
    check("abort/done", {31'b0, done}, 32'd0);
    check("abort/sum",  {16'b0, sum},  32'd0);
    check("abort/cout", {31'b0, cout}, 32'd0);
    check("abort/err",  {31'b0, err},  32'd0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort/no_done", ndone, 32'd0);
    run_op(16'h1234, 16'h1111, 1'b0, "after_abort");
    check("after_abort/sum_const", {16'b0, sum}, 32'h2345);

    // Non-BCD digit.
    run_op(16'h00A0, 16'h0000, 1'b0, "invalid");
    check("invalid/sum_const", {16'b0, sum}, 32'h0100);

    // Randomized operands against the reference model.
    for (int n = 0; n < 24; n++) begin
      ra = '0;
      rb = '0;
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = rand_digit();
        rb[4*i +: 4] = rand_digit();
      end
      run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
